text_buf_ctrl: RTL

TEXT_BUF_CTRL -- requirements
Module: text_buf_ctrl

---
 rtl/text_pkg.sv | 19 +
 rtl/text_buf_ctrl_rr_arb2.sv | 23 ++
 rtl/text_buf_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the character text buffer controller.
// Holds the default fill code, screen geometry and the controller state encoding.
package text_pkg;

    // Code written to every cell by a full-screen clear (ASCII space).
    localparam logic [6:0] DEF_FILL_CHAR = 7'h20;

    // Screen geometry: 32 columns x 8 rows, address = {row[2:0], col[4:0]}.
    localparam int TEXT_COLS = 32;
    localparam int TEXT_ROWS = 8;
    localparam int DEF_CELLS = TEXT_COLS * TEXT_ROWS;

    // Controller states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/text_buf_ctrl_rr_arb2.sv
// Two-way round-robin grant logic.
// Ports:
//   req[1:0]  eligible requests (already masked by the caller)
//   last      index of the requester granted most recently
//   gnt[1:0]  one-hot grant (or zero when nobody is eligible)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Single requester wins outright; on a tie the one not granted last wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/text_buf_ctrl.sv
// Character text buffer write controller.
// Arbitrates two write requesters onto the character RAM write port and
// performs full-screen clears, writing only during vertical blanking.
// Ports:
//   pclk, rst               pixel clock, synchronous active-high reset
//   vblnk                   vertical blanking; RAM writes only while high
//   req0/1, addr0/1, data0/1  requester write requests with cell address and ASCII code
//   ack0/1                  one-cycle grant pulse per requester
//   clr_req                 single-cycle pulse requesting a full-screen clear
//   clr_done                one-cycle pulse coincident with the final clear write
//   busy                    high while a clear is pending or in progress
//   wr_en, wr_addr, wr_data character RAM write port
// All outputs are registered.
module text_buf_ctrl
    import text_pkg::*;
#(
    parameter logic [6:0] FILL_CHAR = DEF_FILL_CHAR,
    parameter int         CELLS     = DEF_CELLS
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [6:0] data0,
    input  logic [6:0] data1,
    output logic       ack0,
    output logic       ack1,
    input  logic       clr_req,
    output logic       clr_done,
    output logic       busy,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [6:0] wr_data
);

    localparam logic [7:0] LAST_ADDR = 8'(CELLS - 1);

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic       pend_r, pend_s;
    logic       last_r, last_s;
    logic       wr_en_r, wr_en_s;
    logic [7:0] wr_addr_r, wr_addr_s;
    logic [6:0] wr_data_r, wr_data_s;
    logic       ack0_r, ack0_s;
    logic       ack1_r, ack1_s;
    logic       clr_done_r, clr_done_s;
    logic       busy_r, busy_s;
    logic [1:0] elig_s;
    logic [1:0] gnt_s;

    // A requester whose ack is showing this cycle is treated as idle, so a
    // held req cannot be granted twice for the same address/data.
    assign elig_s = {req1 & ~ack1_r, req0 & ~ack0_r};

    rr_arb2 u_arb (
        .req  (elig_s),
        .last (last_r),
        .gnt  (gnt_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        pend_s     = pend_r;
        last_s     = last_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = 8'h00;
        wr_data_s  = 7'h00;
        ack0_s     = 1'b0;
        ack1_s     = 1'b0;
        clr_done_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    pend_s = 1'b1;
                end else begin
                    pend_s = pend_r;
                end

                // Decisions use the registered pending flag, so a clear
                // requested alongside a write lets that write finish first.
                if (vblnk && pend_r) begin
                    state_s = ST_CLEAR;
                    cnt_s   = 8'h00;
                    pend_s  = 1'b0;
                end else if (vblnk && (gnt_s != 2'b00)) begin
                    wr_en_s = 1'b1;
                    if (gnt_s[0]) begin
                        ack0_s    = 1'b1;
                        wr_addr_s = addr0;
                        wr_data_s = data0;
                        last_s    = 1'b0;
                    end else begin
                        ack1_s    = 1'b1;
                        wr_addr_s = addr1;
                        wr_data_s = data1;
                        last_s    = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                // Outside blanking the counter simply holds its place.
                if (vblnk) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cnt_r;
                    wr_data_s = FILL_CHAR;
                    cnt_s     = cnt_r + 8'd1;
                    if (cnt_r == LAST_ADDR) begin
                        state_s    = ST_IDLE;
                        clr_done_s = 1'b1;
                    end else begin
                        state_s = ST_CLEAR;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'h00;
                pend_s  = 1'b0;
            end
        endcase

        // busy covers pending, active clear, and the clr_done cycle itself.
        busy_s = pend_s | (state_s == ST_CLEAR) | clr_done_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'h00;
            pend_r     <= 1'b0;
            last_r     <= 1'b1;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 8'h00;
            wr_data_r  <= 7'h00;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            clr_done_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pend_r     <= pend_s;
            last_r     <= last_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            ack0_r     <= ack0_s;
            ack1_r     <= ack1_s;
            clr_done_r <= clr_done_s;
            busy_r     <= busy_s;
        end
    end

    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign clr_done = clr_done_r;
    assign busy     = busy_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;

endmodule
